// File: rtl/kbd_num_entry_pkg.sv
// Shared definitions for the keyboard number-entry path: PS/2 set-2 scan
// codes for the keys we act on, the entry FSM states and a digit decoder.
package kbd_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_MINUS = 8'h4E;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    PUSH
  } state_e;

  // Returns {valid, digit}; valid is 0 for any non-digit scan code.
  function automatic logic [4:0] sc_to_digit(input logic [7:0] sc);
    logic [4:0] r;
    r = 5'b0;
    case (sc)
      SC_0:    r = {1'b1, 4'd0};
      SC_1:    r = {1'b1, 4'd1};
      SC_2:    r = {1'b1, 4'd2};
      SC_3:    r = {1'b1, 4'd3};
      SC_4:    r = {1'b1, 4'd4};
      SC_5:    r = {1'b1, 4'd5};
      SC_6:    r = {1'b1, 4'd6};
      SC_7:    r = {1'b1, 4'd7};
      SC_8:    r = {1'b1, 4'd8};
      SC_9:    r = {1'b1, 4'd9};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbd_num_entry_sync_fifo.sv
// Small synchronous FIFO with occupancy counter; DEPTH must be a power of
// two so the pointers wrap naturally. dout reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];

  // Storage array; no reset needed since dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/kbd_num_entry.sv
// Keyboard decimal number entry: edits a BCD entry on key release, converts
// it to binary on Enter (one digit per cycle) and queues results for the CPU.
//
//   state   | meaning
//   IDLE    | accepting edit keys and Enter
//   CONVERT | folding one BCD digit per cycle into the accumulator, MSD first
//   PUSH    | saturate/negate, write FIFO, clear the entry
module kbd_num_entry #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIGITS = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int SIGNED     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [15:0]                         code,
  input  logic                                status,
  output logic                                control,
  output logic [DATA_WIDTH-1:0]               num,
  output logic                                full,
  output logic [4*MAX_DIGITS-1:0]             entry_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]     entry_cnt,
  output logic                                entry_neg,
  output logic                                err
);

  import kbd_pkg::*;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int AW = DATA_WIDTH + 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [AW-1:0] LIM_U = {4'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [AW-1:0] LIM_P = {5'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] LIM_N = {4'b0, 1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [15:0]             code_q;
  logic                    status_q;
  logic [4*MAX_DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]           cnt_q, cnt_d, idx_q, idx_d;
  logic                    neg_q, neg_d;
  logic [AW-1:0]           acc_q, acc_d, acc_next, limit;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
  logic                    key_evt;
  logic [4:0]              dig;
  logic [3:0]              cur_dig;
  logic [DATA_WIDTH-1:0]   mag, fifo_din, fifo_dout;
  logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;

  assign key_evt  = (code != code_q) && (code[15:8] == SC_BREAK);
  assign dig      = sc_to_digit(code[7:0]);
  assign cur_dig  = bcd_q[{idx_q, 2'b00} +: 4];
  assign acc_next = (acc_q << 3) + (acc_q << 1) + AW'(cur_dig);
  assign limit    = (SIGNED != 0) ? (neg_q ? LIM_N : LIM_P) : LIM_U;
  assign mag      = ovf_q ? limit[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
  assign fifo_pop = status_q && !status && !fifo_empty;

  // Next-state logic for the entry editor, converter and error pulse.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    err_d     = 1'b0;
    fifo_push = 1'b0;
    fifo_din  = '0;
    case (state_q)
      IDLE: begin
        if (key_evt) begin
          if (dig[4]) begin
            if (cnt_q < MAX_CNT) begin
              bcd_d = {bcd_q[4*MAX_DIGITS-5:0], dig[3:0]};
              cnt_d = cnt_q + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (code[7:0])
              SC_BKSP: begin
                if (cnt_q != '0) begin
                  bcd_d = {4'h0, bcd_q[4*MAX_DIGITS-1:4]};
                  cnt_d = cnt_q - CW'(1);
                end
              end
              SC_MINUS: if (SIGNED != 0) neg_d = !neg_q;
              SC_ESC: begin
                bcd_d = '0;
                cnt_d = '0;
                neg_d = 1'b0;
              end
              SC_ENTER: begin
                if (cnt_q != '0) begin
                  if (fifo_full) begin
                    err_d = 1'b1;
                  end else begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = cnt_q - CW'(1);
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
      CONVERT: begin
        err_d = key_evt;
        acc_d = acc_next;
        if (acc_next > limit) ovf_d = 1'b1;
        if (idx_q == '0) state_d = PUSH;
        else             idx_d   = idx_q - CW'(1);
      end
      PUSH: begin
        err_d     = key_evt || ovf_q;
        fifo_push = 1'b1;
        fifo_din  = neg_q ? -mag : mag;
        bcd_d     = '0;
        cnt_d     = '0;
        neg_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      status_q <= 1'b0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code;
      status_q <= status;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign control   = !fifo_empty;
  assign num       = fifo_dout;
  assign full      = fifo_full;
  assign entry_bcd = bcd_q;
  assign entry_cnt = cnt_q;
  assign entry_neg = neg_q;
  assign err       = err_q;

endmodule
